// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - four-LED pattern sequencer with prescaled step tick and mode/pause buttons
//
// Ports:
//   clk        : board clock, all state on the rising edge
//   rst_n      : asynchronous active-low reset
//   btn_mode   : raw mode button (async, active-high), advances mode on each press
//   btn_pause  : raw pause button (async, active-high), toggles paused on each press
//   led        : pattern register, straight from a flop
//   mode       : 0 ROT_L, 1 ROT_R, 2 BOUNCE, 3 BLINK
//   paused     : high while stepping is suspended
//   step_pulse : one-cycle strobe in the cycle led shows a freshly stepped value

module led_pattern_ctrl #(
  parameter int unsigned DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_pause,
  output logic [3:0] led,
  output logic [1:0] mode,
  output logic       paused,
  output logic       step_pulse
);

  localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  localparam logic [1:0] M_ROT_L  = 2'd0;
  localparam logic [1:0] M_ROT_R  = 2'd1;
  localparam logic [1:0] M_BOUNCE = 2'd2;
  localparam logic [1:0] M_BLINK  = 2'd3;

  logic [CW-1:0] cnt;
  logic          mode_s1, mode_s2, mode_d;
  logic          pause_s1, pause_s2, pause_d;
  logic          dir_right;   // bounce direction, 0 = walking toward led[3]
  logic          mode_edge, pause_edge, tick;
  logic [1:0]    next_mode;

  // Rising-edge detect on the synchronized button; a held button fires once.
  assign mode_edge  = mode_s2 & ~mode_d;
  assign pause_edge = pause_s2 & ~pause_d;
  assign tick       = ~paused & (cnt == LAST);
  assign next_mode  = mode + 2'd1;

  function automatic logic [3:0] reload_value(input logic [1:0] m);
    return (m == M_BLINK) ? 4'b1111 : 4'b0001;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_s1    <= 1'b0;
      mode_s2    <= 1'b0;
      mode_d     <= 1'b0;
      pause_s1   <= 1'b0;
      pause_s2   <= 1'b0;
      pause_d    <= 1'b0;
      cnt        <= '0;
      led        <= 4'b0001;
      mode       <= M_ROT_L;
      paused     <= 1'b0;
      step_pulse <= 1'b0;
      dir_right  <= 1'b0;
    end else begin
      mode_s1  <= btn_mode;
      mode_s2  <= mode_s1;
      mode_d   <= mode_s2;
      pause_s1 <= btn_pause;
      pause_s2 <= pause_s1;
      pause_d  <= pause_s2;

      // Pause toggles independently; a tick in the same cycle still steps
      // because tick was qualified by the old paused value.
      if (pause_edge) begin
        paused <= ~paused;
      end

      if (mode_edge) begin
        // Mode change restarts the period and overrides a coincident tick.
        mode       <= next_mode;
        led        <= reload_value(next_mode);
        dir_right  <= 1'b0;
        cnt        <= '0;
        step_pulse <= 1'b0;
      end else if (tick) begin
        cnt        <= '0;
        step_pulse <= 1'b1;
        case (mode)
          M_ROT_L: led <= {led[2:0], led[3]};
          M_ROT_R: led <= {led[0], led[3:1]};
          M_BOUNCE: begin
            // Direction flips on the step that lands on an end position.
            if (!dir_right) begin
              led <= {led[2:0], 1'b0};
              if (led[2]) dir_right <= 1'b1;
            end else begin
              led <= {1'b0, led[3:1]};
              if (led[1]) dir_right <= 1'b0;
            end
          end
          default: led <= ~led;
        endcase
      end else begin
        step_pulse <= 1'b0;
        if (!paused) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb/tb_led_pattern_ctrl.sv - randomized self-checking bench for led_pattern_ctrl against a pattern-index model

module tb_led_pattern_ctrl;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_mode;
  logic       btn_pause;
  logic [3:0] led;
  logic [1:0] mode;
  logic       paused;
  logic       step_pulse;

  int vectors;
  int miscompares;

  led_pattern_ctrl #(.DIV(DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_mode  (btn_mode),
    .btn_pause (btn_pause),
    .led       (led),
    .mode      (mode),
    .paused    (paused),
    .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: a button press is seen two edges after it is first
  // sampled; the LED value is a pure function of mode and the number of
  // whole periods run since the last reload.
  logic [1:0] e_mode;
  logic       e_paused;
  logic       e_pulse;
  int         e_el;        // running (unpaused) cycles since the last reload
  logic [3:1] hm, hp;      // button samples from 1, 2, 3 edges ago

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_mode   <= 2'd0;
      e_paused <= 1'b0;
      e_pulse  <= 1'b0;
      e_el     <= 0;
      hm       <= '0;
      hp       <= '0;
    end else begin
      hm <= {hm[2:1], btn_mode};
      hp <= {hp[2:1], btn_pause};
      if (hm[2] && !hm[3]) begin
        e_mode  <= e_mode + 2'd1;
        e_el    <= 0;
        e_pulse <= 1'b0;
      end else if (!e_paused) begin
        e_el    <= e_el + 1;
        e_pulse <= ((e_el + 1) % DIV) == 0;
      end else begin
        e_pulse <= 1'b0;
      end
      if (hp[2] && !hp[3]) e_paused <= !e_paused;
    end
  end

  function automatic logic [3:0] pattern(input logic [1:0] m, input int idx);
    logic [3:0] one;
    one = 4'b0001;
    case (m)
      2'd0: return one << (idx % 4);
      2'd1: return one << ((4 - idx % 4) % 4);
      2'd2: begin
        case (idx % 6)
          0: return 4'b0001;
          1: return 4'b0010;
          2: return 4'b0100;
          3: return 4'b1000;
          4: return 4'b0100;
          default: return 4'b0010;
        endcase
      end
      default: return (idx % 2 == 0) ? 4'b1111 : 4'b0000;
    endcase
  endfunction

  // Advance one clock and compare all outputs with the model.
  task automatic cyc();
    logic [3:0] el;
    @(posedge clk);
    @(negedge clk);
    el = pattern(e_mode, e_el / DIV);
    vectors++;
    if (led !== el || mode !== e_mode || paused !== e_paused || step_pulse !== e_pulse) begin
      miscompares++;
      $display("FAIL model t=%0t: led=%b mode=%0d paused=%b pulse=%b, required led=%b mode=%0d paused=%b pulse=%b",
               $time, led, mode, paused, step_pulse, el, e_mode, e_paused, e_pulse);
    end
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, required %b", name, got, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait budget expired", name);
  endtask

  task automatic press(input logic pm, input logic pp, input int hold);
    btn_mode  = pm;
    btn_pause = pp;
    repeat (hold) cyc();
    btn_mode  = 1'b0;
    btn_pause = 1'b0;
    cyc();
  endtask

  initial begin
    int n, t, changes;
    logic [3:0] held;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    btn_mode    = 1'b0;
    btn_pause   = 1'b0;

    repeat (3) cyc();
    check("reset_state", {led, mode, paused, step_pulse}, 8'b0001_00_0_0);
    rst_n = 1'b1;

    // ROT_L: five steps in 20 cycles.
    n = 0;
    repeat (20) begin
      cyc();
      if (step_pulse) n++;
    end
    check("rotl_pulse_count", 8'(n), 8'd5);
    check("rotl_led_20", {4'b0, led}, 8'b0000_0010);

    press(1'b1, 1'b0, 1);
    cyc();
    check("mode_rotr", {led, mode, step_pulse}, 8'b0001_01_0_0 >> 1);
    repeat (32) cyc();
    check("rotr_8steps", {led, step_pulse}, {3'b0, 4'b0001, 1'b1});

    press(1'b1, 1'b0, 1);
    cyc();
    check("mode_bounce", {6'b0, mode}, 8'd2);
    repeat (16) cyc();
    check("bounce_4steps", {4'b0, led}, 8'b0000_0100);

    press(1'b1, 1'b0, 1);
    cyc();
    check("mode_blink", {led, mode, step_pulse, 1'b0}, 8'b1111_11_0_0);

    press(1'b1, 1'b0, 1);
    cyc();
    check("mode_wrap", {led, mode, step_pulse, 1'b0}, 8'b0001_00_0_0);

    // Held button: exactly one increment, visible three edges after rising.
    btn_mode = 1'b1;
    cyc();
    cyc();
    check("hold_not_yet", {6'b0, mode}, 8'd0);
    cyc();
    check("hold_third_edge", {6'b0, mode}, 8'd1);
    repeat (97) cyc();
    btn_mode = 1'b0;
    repeat (3) cyc();
    check("hold_single_inc", {6'b0, mode}, 8'd1);

    // Pause: frozen LEDs, resume keeps the partial period.
    t = 0;
    while (!(!e_paused && e_el % DIV == 0) && t < 100) begin cyc(); t++; end
    if (t >= 100) timeout_fail("pause_align");
    press(1'b0, 1'b1, 1);
    cyc();
    check("paused_set", {7'b0, paused}, 8'd1);
    held = led;
    changes = 0;
    repeat (50) begin
      cyc();
      if (led !== held || step_pulse) changes++;
    end
    check("pause_frozen", 8'(changes), 8'd0);
    press(1'b0, 1'b1, 1);
    cyc();
    check("paused_clear", {7'b0, paused}, 8'd0);
    n = 0;
    t = 0;
    while (t < 10) begin
      cyc();
      n++;
      t++;
      if (step_pulse) break;
    end
    check("resume_latency", 8'(n), 8'd1);

    // Mode edge landing on a tick: reload wins, no pulse, next step DIV later.
    t = 0;
    while (!(!e_paused && e_el % DIV == DIV - 3) && t < 100) begin cyc(); t++; end
    if (t >= 100) timeout_fail("tick_align");
    press(1'b1, 1'b0, 1);
    cyc();
    check("tick_collide", {led, mode, step_pulse, 1'b0}, 8'b0001_10_0_0);
    n = 0;
    repeat (3) begin
      cyc();
      if (step_pulse) n++;
    end
    check("collide_no_early_step", 8'(n), 8'd0);
    cyc();
    check("collide_next_step", {3'b0, led, step_pulse}, {3'b0, 4'b0010, 1'b1});

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: press(1'b1, 1'b0, $urandom_range(1, 6));
        3, 4:    press(1'b0, 1'b1, $urandom_range(1, 6));
        5:       press(1'b1, 1'b1, $urandom_range(1, 3));
        6: begin
          #2 rst_n = 1'b0;
          repeat ($urandom_range(1, 2)) cyc();
          rst_n = 1'b1;
        end
        default: repeat ($urandom_range(1, 12)) cyc();
      endcase
    end

    // Reset in the middle of BOUNCE while walking right from 0100.
    repeat (4) cyc();
    if (e_paused) begin
      press(1'b0, 1'b1, 1);
      repeat (2) cyc();
    end
    t = 0;
    while (e_mode != 2'd2 && t < 8) begin
      press(1'b1, 1'b0, 1);
      cyc();
      t++;
    end
    if (e_mode != 2'd2) timeout_fail("reach_bounce");
    t = 0;
    while (!((e_el / DIV) % 6 == 4 && e_el % DIV == 1) && t < 200) begin cyc(); t++; end
    if (t >= 200) timeout_fail("bounce_align");
    check("pre_reset_led", {led, mode, paused, 1'b0}, 8'b0100_10_0_0);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {led, mode, paused, step_pulse}, 8'b0001_00_0_0);
    cyc();
    cyc();
    rst_n = 1'b1;
    repeat (DIV) cyc();
    check("post_reset_step", {3'b0, led, step_pulse}, {3'b0, 4'b0010, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Pattern sequencer for the Basys3 four-LED display. Generates its own step tick from the 100 MHz board clock, holds the LED pattern register, and advances it according to a user-selected mode. Two push-buttons select the mode and pause/resume the pattern. Sits between the board clock/button pins and the `led[3:0]` pins in the top level.

## Interface
- `DIV`, default 100_000_000: clock cycles per pattern step (1 Hz at 100 MHz); legal range 2 to 2^27; benches use small values (e.g. 4).
- `clk`  input  1  100 MHz board clock; all state on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `btn_mode`  input  1  raw mode button, asynchronous to `clk`, active-high; bounce filtering is external.
- `btn_pause`  input  1  raw pause button, asynchronous, active-high.
- `led`  output  4  pattern register, driven directly from a flop.
- `mode`  output  2  current mode: 0 ROT_L, 1 ROT_R, 2 BOUNCE, 3 BLINK.
- `paused`  output  1  high while stepping is suspended.
- `step_pulse`  output  1  one-cycle strobe, high in the cycle `led` shows a newly stepped value.

## Operation
- Reset values (async, on `rst_n`=0): `led`=4'b0001, `mode`=0, `paused`=0, `step_pulse`=0, prescaler=0, bounce direction=left, all synchronizer flops=0.
- Each button passes through a 2-flop synchronizer and a delay flop. Edge = sync_out & ~delayed; each edge is acted on exactly once; held buttons do not repeat.
- Prescaler: counter of width clog2(DIV), counts 0..DIV-1 while not paused. At DIV-1 it wraps to 0 and raises an internal tick for that cycle. While `paused`=1 the counter holds its value and no tick is generated.
- On a tick, `led` updates on the next edge and `step_pulse` is high for that one cycle:
  - ROT_L: led <= {led[2:0], led[3]}: 0001,0010,0100,1000,0001...
  - ROT_R: led <= {led[0], led[3:1]}: 0001,1000,0100,0010,0001...
  - BOUNCE: single bit walks left to 1000, then right to 0001, then left again: 0001,0010,0100,1000,0100,0010,0001,0010... Direction flips on the step that reaches 1000 or 0001.
  - BLINK: led <= ~led: 1111,0000,1111...
- Mode edge: `mode` <= mode+1, wrapping 3->0. Also:
  - `led` reloads: 0001 for modes 0-2, 1111 for mode 3.
  - Bounce direction resets to left.
  - Prescaler clears to 0.
  - `step_pulse` stays 0 for that cycle.
- Pause edge: toggles `paused`. Resuming continues from the held prescaler value, so there is no extra or lost partial period.
- Mode change is allowed while paused. It reloads `led` and clears the prescaler; `paused` stays 1.

## Timing
- Button rising at the input just before clock edge k: captured by sync flop 1 at edge k, sync flop 2 at k+1. The edge is detected combinationally in the following cycle, and `mode`/`paused` change at edge k+2. Three-flop input path, no combinational input-to-output path.
- Step period is exactly DIV cycles between consecutive `step_pulse` assertions while running with no mode edges.
- After reset release, the first `step_pulse` occurs DIV cycles after the first active clock edge.
- After a mode change at edge m, the first new step occurs at edge m+DIV.
- Mode edge coinciding with a tick: the mode change wins, the tick is discarded, and `led` shows the reload value.
- Pause edge coinciding with a tick: the tick is honored (led steps) and `paused` sets in the same edge.
- Mode and pause edges in the same cycle: both take effect.
- Reset asserted mid-step: all outputs reach reset values immediately (asynchronous). Release is sampled synchronously on the next `clk` edge.

## Test plan
- DIV=4, reset then run 20 cycles in ROT_L -> `led` 0001,0010,0100,1000,0001, changing every 4 cycles. `step_pulse` is high exactly on each change.
- DIV=4, pulse `btn_mode` once per run, collecting 8 steps per mode:
  - ROT_R -> `mode`=1, led 0001,1000,0100,0010.
  - BOUNCE -> `mode`=2, led 0001,0010,0100,1000,0100,0010,0001,0010.
  - BLINK -> `mode`=3, led 1111,0000,1111.
  - Fourth press -> `mode`=0, led 0001.
- DIV=4, press `btn_pause` midway through a period (prescaler=2), wait 50 cycles, press again -> `paused`=1 with `led` frozen for 50 cycles. After resume, the next step comes 2 cycles after the prescaler restarts counting.
- DIV=4, align the `btn_mode` edge detection with the tick cycle -> `mode` increments, `led` = reload value, no `step_pulse`. Next step follows 4 cycles later.
- Hold `btn_mode` high for 100 cycles -> exactly one mode increment, `mode` visible 3 edges after the input rises.
- Assert `rst_n`=0 asynchronously mid-BOUNCE with `led`=0100, direction=right -> `led`=0001, `mode`=0, `paused`=0 immediately. After release, the first step occurs DIV cycles later and gives 0010.
